// File: rtl/approx_mac_pe_if.sv
// Operand, multiplier and result signals of one systolic MAC processing element.
// The master drives operands, the multiplier product and res_ready; the PE is the slave.
interface approx_mac_pe_if #(
    parameter int ACC_W = 16
);
    logic             start;
    logic [3:0]       a_in;
    logic             a_valid_in;
    logic [3:0]       b_in;
    logic             b_valid_in;
    logic [3:0]       a_out;
    logic             a_valid_out;
    logic [3:0]       b_out;
    logic             b_valid_out;
    logic [3:0]       mult_x;
    logic [3:0]       mult_y;
    logic [7:0]       mult_p;
    logic [ACC_W-1:0] res_out;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic             ovf;
    logic             err;

    modport master (
        output start, a_in, a_valid_in, b_in, b_valid_in, mult_p, res_ready,
        input  a_out, a_valid_out, b_out, b_valid_out, mult_x, mult_y,
               res_out, res_valid, busy, ovf, err
    );

    modport slave (
        input  start, a_in, a_valid_in, b_in, b_valid_in, mult_p, res_ready,
        output a_out, a_valid_out, b_out, b_valid_out, mult_x, mult_y,
               res_out, res_valid, busy, ovf, err
    );
endinterface

// File: rtl/approx_mac_pe.sv
// Output-stationary systolic PE: accumulates K_LEN products from an external
// approximate multiplier into a saturating dot product and forwards operands east/south.
module approx_mac_pe #(
    parameter int K_LEN = 8,
    parameter int ACC_W = 16
) (
    input logic            clk,
    input logic            rst,
    approx_mac_pe_if.slave pe
);
    localparam int CNT_W = $clog2(K_LEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K_LEN - 1);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] res_r;
    logic             res_valid_r, ovf_r, err_r;
    logic [3:0]       a_fwd, b_fwd;
    logic             av_fwd, bv_fwd;
    logic             fire, clr;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat;

    assign fire = (state == S_ACC) && pe.a_valid_in && pe.b_valid_in;
    // start wins over fire; in DONE it only counts once the result is taken
    assign clr  = pe.start && ((state == S_IDLE) || (state == S_ACC) ||
                               ((state == S_DONE) && pe.res_ready));
    assign sum  = {1'b0, acc} + (ACC_W + 1)'(pe.mult_p);
    assign sat  = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            cnt         <= '0;
            res_r       <= '0;
            res_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            a_fwd       <= '0;
            b_fwd       <= '0;
            av_fwd      <= 1'b0;
            bv_fwd      <= 1'b0;
        end else begin
            a_fwd  <= pe.a_in;
            b_fwd  <= pe.b_in;
            av_fwd <= pe.a_valid_in;
            bv_fwd <= pe.b_valid_in;
            if (clr) begin
                state       <= S_ACC;
                acc         <= '0;
                cnt         <= '0;
                ovf_r       <= 1'b0;
                err_r       <= 1'b0;
                res_valid_r <= 1'b0;
            end else begin
                case (state)
                    S_ACC: begin
                        if (fire) begin
                            acc <= sat;
                            cnt <= cnt + 1'b1;
                            if (sum[ACC_W]) ovf_r <= 1'b1;
                            if (cnt == LAST) begin
                                state       <= S_DONE;
                                res_r       <= sat;
                                res_valid_r <= 1'b1;
                            end
                        end else if (pe.a_valid_in ^ pe.b_valid_in) begin
                            err_r <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (pe.res_ready) begin
                            state       <= S_IDLE;
                            res_valid_r <= 1'b0;
                        end
                    end
                    S_IDLE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign pe.mult_x      = fire ? pe.a_in : 4'd0;
    assign pe.mult_y      = fire ? pe.b_in : 4'd0;
    assign pe.a_out       = a_fwd;
    assign pe.a_valid_out = av_fwd;
    assign pe.b_out       = b_fwd;
    assign pe.b_valid_out = bv_fwd;
    assign pe.res_out     = res_r;
    assign pe.res_valid   = res_valid_r;
    assign pe.busy        = (state != S_IDLE);
    assign pe.ovf         = ovf_r;
    assign pe.err         = err_r;
endmodule

// File: tb/tb_approx_mac_pe.sv
// Scoreboard bench for approx_mac_pe: a 16-bit PE with an exact multiplier stub and an
// 8-bit PE with a constant 0xFF product stub for saturation.
module tb_approx_mac_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_mac_pe_if #(.ACC_W(16)) ifa ();
    approx_mac_pe_if #(.ACC_W(8))  ifb ();

    approx_mac_pe #(.K_LEN(8), .ACC_W(16)) dut_a (.clk(clk), .rst(rst), .pe(ifa));
    approx_mac_pe #(.K_LEN(8), .ACC_W(8))  dut_b (.clk(clk), .rst(rst), .pe(ifb));

    assign ifa.mult_p = ifa.mult_x * ifa.mult_y;
    assign ifb.mult_p = 8'hFF;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   fwd_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // forwarding model: what each output register should hold after the last edge
    logic [3:0] fa, fb;
    logic       fav, fbv;
    always @(posedge clk) begin
        fa  <= rst ? 4'd0 : ifa.a_in;
        fb  <= rst ? 4'd0 : ifa.b_in;
        fav <= rst ? 1'b0 : ifa.a_valid_in;
        fbv <= rst ? 1'b0 : ifa.b_valid_in;
    end

    // monitor: pops expected results on each rising res_valid, checks hold while valid
    logic        pva = 1'b0, pvb = 1'b0;
    logic [15:0] hold_a;
    logic [7:0]  hold_b;
    always @(negedge clk) begin
        exp_t e;
        if (fwd_en) begin
            chk("fwd_a", {28'd0, ifa.a_out}, {28'd0, fa});
            chk("fwd_b", {28'd0, ifa.b_out}, {28'd0, fb});
            chk("fwd_valids", {30'd0, ifa.a_valid_out, ifa.b_valid_out}, {30'd0, fav, fbv});
        end
        if (ifa.res_valid === 1'b1 && !pva) begin
            if (qa.size() == 0) chk("a_unexpected_result", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_res", {16'd0, ifa.res_out}, {16'd0, e.res});
                chk("a_flags", {30'd0, ifa.ovf, ifa.err}, {30'd0, e.ovf, e.err});
                chk("a_latency", cyc, e.cyc);
            end
        end else if (ifa.res_valid === 1'b1 && pva) begin
            chk("a_res_hold", {16'd0, ifa.res_out}, {16'd0, hold_a});
        end
        if (ifb.res_valid === 1'b1 && !pvb) begin
            if (qb.size() == 0) chk("b_unexpected_result", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_res", {24'd0, ifb.res_out}, {16'd0, e.res});
                chk("b_flags", {30'd0, ifb.ovf, ifb.err}, {30'd0, e.ovf, e.err});
                chk("b_latency", cyc, e.cyc);
            end
        end
        pva    = (ifa.res_valid === 1'b1);
        pvb    = (ifb.res_valid === 1'b1);
        hold_a = ifa.res_out;
        hold_b = ifb.res_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic [3:0] a, input logic av, input logic [3:0] b,
                         input logic bv, input logic st);
        ifa.a_in = a; ifa.a_valid_in = av; ifa.b_in = b; ifa.b_valid_in = bv; ifa.start = st;
    endtask

    task automatic start_a();
        drv_a(4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic fires_a(input int n, input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < n; i++) begin
            drv_a(a, 1'b1, b, 1'b1, 1'b0);
            tick();
        end
        drv_a(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic push_a(input logic [15:0] r, input logic o, input logic e);
        exp_t x;
        x.res = r; x.ovf = o; x.err = e; x.cyc = cyc;
        qa.push_back(x);
    endtask

    initial begin
        exp_t x;
        drv_a(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        ifa.res_ready = 1'b1;
        ifb.start = 1'b0; ifb.a_in = 4'd0; ifb.a_valid_in = 1'b0;
        ifb.b_in = 4'd0; ifb.b_valid_in = 1'b0; ifb.res_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        fwd_en = 1'b1;

        // reset state
        chk("rst_res", {15'd0, ifa.res_valid, ifa.res_out}, 32'd0);
        chk("rst_flags", {29'd0, ifa.busy, ifa.ovf, ifa.err}, 32'd0);
        chk("rst_fwd", {22'd0, ifa.a_out, ifa.b_out, ifa.a_valid_out, ifa.b_valid_out}, 32'd0);
        chk("rst_mult", {24'd0, ifa.mult_x, ifa.mult_y}, 32'd0);

        // 1: 8 x (3*5) = 120
        start_a();
        chk("t1_busy", {31'd0, ifa.busy}, 32'd1);
        drv_a(4'd3, 1'b1, 4'd5, 1'b1, 1'b0);
        #1 chk("t1_mult_gated_on", {24'd0, ifa.mult_x, ifa.mult_y}, {24'd0, 8'h35});
        fires_a(8, 4'd3, 4'd5);
        push_a(16'd120, 1'b0, 1'b0);
        tick();
        chk("t1_back_idle", {30'd0, ifa.busy, ifa.res_valid}, 32'd0);

        // 2: 8-bit build with 0xFF products saturates on the second fire
        ifb.start = 1'b1; tick(); ifb.start = 1'b0;
        ifb.a_valid_in = 1'b1; ifb.b_valid_in = 1'b1; ifb.a_in = 4'd1; ifb.b_in = 4'd1;
        tick();
        chk("t2_no_ovf_yet", {31'd0, ifb.ovf}, 32'd0);
        tick();
        chk("t2_ovf", {31'd0, ifb.ovf}, 32'd1);
        repeat (6) tick();
        ifb.a_valid_in = 1'b0; ifb.b_valid_in = 1'b0;
        x.res = 16'd255; x.ovf = 1'b1; x.err = 1'b0; x.cyc = cyc;
        qb.push_back(x);
        tick();
        ifb.start = 1'b1; tick(); ifb.start = 1'b0;
        chk("t2_ovf_cleared", {30'd0, ifb.ovf, ifb.busy}, 32'd1);

        // 3: a-only / b-only / both; both-valid a values 2,5,8,11,14,1,4,7 sum to 52
        start_a();
        for (int i = 0; i < 24; i++) begin
            drv_a(4'(i), (i % 3) != 1, 4'd1, (i % 3) != 0, 1'b0);
            tick();
        end
        drv_a(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        push_a(16'd52, 1'b0, 1'b1);
        tick();

        // 4: result held while res_ready=0, start ignored; ready+start goes straight to ACC
        ifa.res_ready = 1'b0;
        start_a();
        fires_a(8, 4'd4, 4'd4);
        push_a(16'd128, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ifa.start = (i % 2) == 0;
            tick();
            chk("t4_held", {30'd0, ifa.busy, ifa.res_valid}, 32'd3);
        end
        ifa.res_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("t4_skip_idle", {30'd0, ifa.busy, ifa.res_valid}, 32'd2);
        fires_a(8, 4'd1, 4'd2);
        push_a(16'd16, 1'b0, 1'b0);
        tick();

        // 5: restart mid-accumulation discards partial sum and the start-cycle operands
        start_a();
        fires_a(4, 4'd2, 4'd2);
        drv_a(4'd2, 1'b1, 4'd2, 1'b1, 1'b1);
        tick();
        fires_a(8, 4'd1, 4'd1);
        push_a(16'd8, 1'b0, 1'b0);
        tick();

        // 6: reset after 5 fires clears everything; fires ignored until start
        start_a();
        fires_a(5, 4'd3, 4'd3);
        drv_a(4'd3, 1'b1, 4'd3, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv_a(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t6_rst_outs", {13'd0, ifa.res_valid, ifa.busy, ifa.ovf, ifa.res_out}, 32'd0);
        chk("t6_rst_fwd", {22'd0, ifa.a_out, ifa.b_out, ifa.a_valid_out, ifa.b_valid_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drv_a(4'd3, 1'b1, 4'd3, 1'b1, 1'b0);
            #1 chk("t6_idle_gated", {23'd0, ifa.busy, ifa.mult_x, ifa.mult_y}, 32'd0);
            tick();
        end
        start_a();
        fires_a(8, 4'd1, 4'd1);
        push_a(16'd8, 1'b0, 1'b0);

        // every expected result must have been seen
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        chk("queues_drained", qa.size() + qb.size(), 32'd0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
